// File: rtl/mips_muldiv_ctrl.sv
// Iterative MIPS32 multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU
// over WIDTH shift cycles plus one sign-fix cycle, and stalls dependent EX ops.
module mips_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mf_req,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   operand;
    logic               is_div, neg_res, neg_rem, zero_div;

    logic               signed_op;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] product, product_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign signed_op = ~op[0];
    assign busy      = (state != IDLE);
    assign stall     = busy & (start | mf_req | mthi | mtlo);

    always_comb begin
        rs_mag = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        rt_mag = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    end

    // acc is the running product high half / partial remainder; shreg holds
    // the multiplier shifting out while product bits shift in, or the
    // dividend shifting out while quotient bits shift in.
    always_comb begin
        mul_sum     = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
        div_shift   = {acc, shreg[WIDTH-1]};
        div_diff    = div_shift - {1'b0, operand};
        product     = {acc, shreg};
        product_fix = neg_res ? -product : product;
        quot_fix    = neg_res ? -shreg : shreg;
        rem_fix     = neg_rem ? -acc : acc;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = BUSY;
            BUSY:    if (count == CNT_W'(1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count    <= '0;
            acc      <= '0;
            shreg    <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            zero_div <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        shreg    <= rs_mag;
                        operand  <= rt_mag;
                        count    <= CNT_W'(WIDTH);
                        is_div   <= op[1];
                        neg_res  <= signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        neg_rem  <= signed_op & rs_val[WIDTH-1];
                        zero_div <= op[1] & (rt_val == '0);
                    end else begin
                        if (mthi) hi <= mt_data;
                        if (mtlo) lo <= mt_data;
                    end
                end
                BUSY: begin
                    count <= count - CNT_W'(1);
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc   <= div_diff[WIDTH-1:0];
                            shreg <= {shreg[WIDTH-2:0], 1'b1};
                        end else begin
                            acc   <= div_shift[WIDTH-1:0];
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc   <= mul_sum[WIDTH:1];
                        shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    // A zero divisor leaves the dividend magnitude in acc, so
                    // rem_fix already reproduces the original rs value.
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= zero_div ? '1 : quot_fix;
                    end else begin
                        hi <= product_fix[2*WIDTH-1:WIDTH];
                        lo <= product_fix[WIDTH-1:0];
                    end
                    done     <= 1'b1;
                    div_zero <= zero_div;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Scoreboard bench for mips_muldiv_ctrl: issued ops push reference results,
// a negedge monitor pops and checks them on every done pulse.
module tb_mips_muldiv_ctrl;

    localparam int W = 32;

    logic         clk, reset, start, mf_req, mthi, mtlo;
    logic [1:0]   op;
    logic [W-1:0] rs_val, rt_val, mt_data;
    logic [W-1:0] hi, lo;
    logic         busy, stall, done, div_zero;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    mips_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .mf_req(mf_req),
        .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall),
        .done(done), .div_zero(div_zero)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference results from plain 64-bit arithmetic, independent of the shift datapath.
    function automatic exp_t refModel(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      x, y, q, r;
        logic [63:0] p;
        e.dz = 1'b0;
        e.t0 = 0;
        e.hi = '0;
        e.lo = '0;
        if (o[1] && b == 0) begin
            e.hi = a;
            e.lo = '1;
            e.dz = 1'b1;
        end else begin
            case (o)
                2'b00: begin
                    p = longint'($signed(a)) * longint'($signed(b));
                    e.hi = p[63:32];
                    e.lo = p[31:0];
                end
                2'b01: begin
                    p = {32'b0, a} * {32'b0, b};
                    e.hi = p[63:32];
                    e.lo = p[31:0];
                end
                2'b10: begin
                    x = longint'($signed(a));
                    y = longint'($signed(b));
                    q = x / y;
                    r = x % y;
                    e.hi = r[31:0];
                    e.lo = q[31:0];
                end
                default: begin
                    e.hi = a % b;
                    e.lo = a / b;
                end
            endcase
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pickOperand();
        case ($urandom % 6)
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("result_hi", hi, mon_e.hi);
                    checkOutput("result_lo", lo, mon_e.lo);
                    checkOutput("result_div_zero", 32'(div_zero), 32'(mon_e.dz));
                    checkOutput("latency", 32'(cyc - mon_e.t0), 32'd33);
                end
            end else if (div_zero) begin
                checkOutput("div_zero_without_done", 32'(div_zero), 32'd0);
            end
        end
    end

    // Holds start until the unit is idle, then logs the expected result.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit hold_next);
        int   g;
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            checkOutput("accept_timeout", 32'(busy), 32'd0);
            start = 1'b0;
            return;
        end
        e    = refModel(o, a, b);
        e.t0 = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold_next) start = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic waitDone(output int nb, output int ns, output bit ok);
        nb = 0;
        ns = 0;
        ok = 1'b0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nb++;
            if (busy && !stall) ns++;
        end
        if (!ok) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic directedOp(input string name, input logic [1:0] o, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                              input logic [W-1:0] exp_lo, input logic exp_dz);
        int nb, ns;
        bit ok;
        applyStimulus(o, a, b, 1'b0);
        waitDone(nb, ns, ok);
        if (ok) begin
            checkOutput({name, "_hi"}, hi, exp_hi);
            checkOutput({name, "_lo"}, lo, exp_lo);
            checkOutput({name, "_div_zero"}, 32'(div_zero), 32'(exp_dz));
        end
    endtask

    initial begin
        int         nb, ns;
        bit         ok, hold;
        logic [1:0] o;
        logic [W-1:0] a, b;

        reset = 0; start = 0; op = 0; rs_val = 0; rt_val = 0;
        mf_req = 0; mthi = 0; mtlo = 0; mt_data = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_div_zero", 32'(div_zero), 32'd0);
        reset = 1;

        @(negedge clk);
        mthi = 1; mt_data = 32'hA5A5A5A5;
        @(negedge clk);
        mthi = 0;
        checkOutput("mthi_hi", hi, 32'hA5A5A5A5);
        checkOutput("mthi_lo_kept", lo, 32'd0);
        mthi = 1; mtlo = 1; mt_data = 32'h13579BDF;
        @(negedge clk);
        mthi = 0; mtlo = 0;
        checkOutput("mt_both_hi", hi, 32'h13579BDF);
        checkOutput("mt_both_lo", lo, 32'h13579BDF);

        applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        waitDone(nb, ns, ok);
        if (ok) begin
            checkOutput("multu_max_busy_cycles", 32'(nb), 32'd33);
            checkOutput("multu_max_busy_at_done", 32'(busy), 32'd0);
            checkOutput("multu_max_hi", hi, 32'hFFFFFFFE);
            checkOutput("multu_max_lo", lo, 32'h00000001);
        end

        directedOp("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        directedOp("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        directedOp("divu_zero", 2'b11, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b1);
        directedOp("div_zero_neg", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
        directedOp("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);

        applyStimulus(2'b01, 32'd6, 32'd7, 1'b0);
        mf_req = 1;
        waitDone(nb, ns, ok);
        if (ok) begin
            checkOutput("mf_stall_missing_cycles", 32'(ns), 32'd0);
            checkOutput("mf_stall_busy_cycles", 32'(nb), 32'd33);
            checkOutput("mf_stall_done_cycle", 32'(stall), 32'd0);
            checkOutput("mf_read_lo", lo, 32'd42);
        end
        mf_req = 0;

        applyStimulus(2'b01, 32'd3, 32'd4, 1'b1);
        applyStimulus(2'b00, 32'hFFFFFFFF, 32'd2, 1'b0);
        waitDone(nb, ns, ok);

        applyStimulus(2'b10, 32'h00001000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1;
        sb.delete();
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            o    = 2'($urandom);
            a    = pickOperand();
            b    = pickOperand();
            hold = ($urandom % 3 == 0) && (i != 39);
            applyStimulus(o, a, b, hold);
        end
        start = 0;

        for (int g = 0; g < 100 && sb.size() > 0; g++) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_ctrl.md
Name: mips_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the MIPS32 pipelined core; sits beside the EX-stage ALU and owns the HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles using one shift/add-subtract datapath, and stalls the pipeline while busy.
- Services MFHI/MFLO/MTHI/MTLO and holds back any dependent or new mul/div instruction until the result is committed.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- start  input  1  EX stage holds a mul/div instruction this cycle
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- rs_val  input  WIDTH  forwarded rs operand (multiplicand/dividend)
- rt_val  input  WIDTH  forwarded rt operand (multiplier/divisor)
- mf_req  input  1  EX stage holds MFHI or MFLO
- mthi  input  1  MTHI in EX
- mtlo  input  1  MTLO in EX
- mt_data  input  WIDTH  data for MTHI/MTLO
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in progress
- stall  output  1  freeze IF/ID/EX, bubble into MEM
- done  output  1  one-cycle pulse when HI/LO are committed by an op
- div_zero  output  1  one-cycle pulse with done when divisor was zero

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; hi, lo, busy, done and div_zero are all 0; counter and internal accumulators are 0. Reset mid-operation aborts the operation, and HI/LO are cleared.
- FSM states: IDLE, BUSY, FIX.
- IDLE with start=1:
  - Latch operands; for signed ops, latch magnitudes and record the sign of each operand.
  - counter=WIDTH; go to BUSY.
  - mthi/mtlo are ignored in the same cycle (start has priority; the pipeline never issues both).
- IDLE with mthi/mtlo, no start: hi (or lo) <= mt_data at the next edge. mthi and mtlo together write both.
- BUSY, multiply: radix-2 shift-add over a 2*WIDTH product, one bit per cycle; counter decrements; when counter reaches 1, go to FIX.
- BUSY, divide: restoring division, one quotient bit per cycle.
- BUSY is held for exactly WIDTH cycles.
- FIX, sign correction, one cycle:
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Commit: hi <= product[63:32] or remainder; lo <= product[31:0] or quotient.
  - done=1 and div_zero as applicable in the following cycle; go to IDLE.
- Latency: start sampled at edge E0; HI/LO updated at edge E(WIDTH+1), i.e. E33. done is high in the cycle after E33.
- busy=1 from after E0 through the FIX cycle; busy=0 in the cycle done is high.
- stall = busy & (start | mf_req | mthi | mtlo), combinational.
  - A mul/div arriving while busy is held in EX and accepted at the first IDLE cycle.
  - MFHI/MFLO in the done cycle reads the new values.
- Divide by zero: lo=all-ones, hi=original rs_val (signed or unsigned); div_zero pulses with done.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
- Operands are not re-sampled during BUSY; rs_val/rt_val changes are ignored.
- start during FIX is stalled, not accepted.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001; done one cycle; busy high for 33 cycles.
- MULT -3 (0xFFFFFFFD) * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678; div_zero and done pulse together.
- MULTU 6*7 followed next cycle by mf_req -> stall=1 for every cycle through FIX, 0 in the done cycle; lo reads 42.
- Back-to-back: start held during busy is accepted after done; reset=0 at cycle 10 of a DIV -> busy=0, hi=lo=0, no done pulse; mthi 0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next cycle.
